// File: rtl/tiro_aliado.sv
// Friendly-ball shot controller: launches from the ship, climbs each frame,
// scores on an enemy overlap, then cools down before the next shot.
module tiro_aliado #(
  parameter int VELOCIDADE      = 4,
  parameter int RAIO            = 3,
  parameter int RECARGA_QUADROS = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick_frame,
  input  logic       ativo,
  input  logic       perdeu,
  input  logic       disparo,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] x_inimigo,
  input  logic [9:0] y_inimigo,
  output logic [9:0] x_bola_aliada,
  output logic [9:0] y_bola_aliada,
  output logic [9:0] raio_bola_aliada,
  output logic       bola_ativa,
  output logic       acerto,
  output logic [7:0] pontos
);

  typedef enum logic [1:0] {
    OCIOSO,
    VOANDO,
    ACERTO,
    RECARGA
  } estado_t;

  localparam logic [10:0] OFS_Y  = 11'd35;
  localparam logic [10:0] VEL11  = 11'(VELOCIDADE);
  localparam logic [10:0] RAIO11 = 11'(RAIO);
  localparam logic [9:0]  PASSO  = 10'(VELOCIDADE);
  localparam logic [9:0]  RAIO10 = 10'(RAIO);
  localparam logic [7:0]  CARGA  = 8'(RECARGA_QUADROS);

  estado_t estado;
  estado_t prox;

  logic       disparo_q;
  logic [7:0] recarga;

  logic tiro;
  logic parar;
  logic acertou;
  logic topo;
  logic fim_recarga;

  logic [10:0] bx;
  logic [10:0] by;
  logic [10:0] ix_lo;
  logic [10:0] ix_hi;
  logic [10:0] iy_lo;
  logic [10:0] iy_hi;
  logic [10:0] lx;
  logic [10:0] ly;

  logic [9:0] x_d;
  logic [9:0] y_d;
  logic [9:0] raio_d;
  logic       bola_d;
  logic       acerto_d;
  logic [7:0] pontos_d;
  logic [7:0] recarga_d;

  assign tiro  = disparo & ~disparo_q;
  assign parar = ~ativo | perdeu;

  // All coordinate sums are 11 bits so an enemy near 1023 cannot wrap.
  assign bx    = {1'b0, x_bola_aliada};
  assign by    = {1'b0, y_bola_aliada};
  assign ix_lo = {1'b0, x_inimigo} + 11'd144;
  assign ix_hi = {1'b0, x_inimigo} + 11'd177;
  assign iy_lo = {1'b0, y_inimigo} + 11'd35;
  assign iy_hi = {1'b0, y_inimigo} + 11'd59;
  assign lx    = {1'b0, x_nave} + 11'd166;
  assign ly    = {1'b0, y_nave} + OFS_Y - RAIO11;

  assign acertou = (bx >= ix_lo) && (bx <= ix_hi)
                && (by >= iy_lo) && (by <= iy_hi);
  assign topo    = by < (OFS_Y + VEL11);

  // Leaving on the tick that counts the last frame gives exactly N ticks.
  assign fim_recarga = recarga <= 8'd1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox = estado;
    if (parar) begin
      prox = OCIOSO;
    end else begin
      case (estado)
        OCIOSO: begin
          if (tiro) prox = VOANDO;
        end
        VOANDO: begin
          if (tick_frame) begin
            if (acertou)   prox = ACERTO;
            else if (topo) prox = RECARGA;
          end
        end
        ACERTO: begin
          prox = RECARGA;
        end
        RECARGA: begin
          if (tick_frame && fim_recarga) prox = OCIOSO;
        end
      endcase
    end
  end

  always_comb begin
    bola_d    = (prox == VOANDO);
    raio_d    = bola_d ? RAIO10 : 10'd0;
    acerto_d  = (prox == ACERTO);
    pontos_d  = pontos;
    x_d       = x_bola_aliada;
    y_d       = y_bola_aliada;
    recarga_d = recarga;
    if (acerto_d && pontos != 8'hFF) begin
      pontos_d = pontos + 8'd1;
    end
    if (parar) begin
      recarga_d = 8'd0;
    end else begin
      if (estado == OCIOSO && tiro) begin
        x_d = lx[9:0];
        y_d = ly[9:0];
      end else if (estado == VOANDO && tick_frame
                   && !acertou && !topo) begin
        y_d = y_bola_aliada - PASSO;
      end
      if (estado != RECARGA && prox == RECARGA) begin
        recarga_d = CARGA;
      end else if (estado == RECARGA && tick_frame
                   && recarga != 8'd0) begin
        recarga_d = recarga - 8'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      disparo_q        <= 1'b0;
      recarga          <= 8'd0;
      x_bola_aliada    <= 10'd0;
      y_bola_aliada    <= 10'd0;
      raio_bola_aliada <= 10'd0;
      bola_ativa       <= 1'b0;
      acerto           <= 1'b0;
      pontos           <= 8'd0;
    end else begin
      disparo_q        <= disparo;
      recarga          <= recarga_d;
      x_bola_aliada    <= x_d;
      y_bola_aliada    <= y_d;
      raio_bola_aliada <= raio_d;
      bola_ativa       <= bola_d;
      acerto           <= acerto_d;
      pontos           <= pontos_d;
    end
  end

endmodule

// File: tb/tb_tiro_aliado.sv
// Directed bench for tiro_aliado: launch, hold-fire, hit, miss,
// abort, async reset, score saturation and hit-versus-top priority.
module tb_tiro_aliado;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       tick_frame;
  logic       ativo;
  logic       perdeu;
  logic       disparo;
  logic [9:0] x_nave;
  logic [9:0] y_nave;
  logic [9:0] x_inimigo;
  logic [9:0] y_inimigo;
  logic [9:0] x_bola_aliada;
  logic [9:0] y_bola_aliada;
  logic [9:0] raio_bola_aliada;
  logic       bola_ativa;
  logic       acerto;
  logic [7:0] pontos;

  int nvec = 0;
  int nerr = 0;
  int n_acerto = 0;

  tiro_aliado dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .tick_frame       (tick_frame),
    .ativo            (ativo),
    .perdeu           (perdeu),
    .disparo          (disparo),
    .x_nave           (x_nave),
    .y_nave           (y_nave),
    .x_inimigo        (x_inimigo),
    .y_inimigo        (y_inimigo),
    .x_bola_aliada    (x_bola_aliada),
    .y_bola_aliada    (y_bola_aliada),
    .raio_bola_aliada (raio_bola_aliada),
    .bola_ativa       (bola_ativa),
    .acerto           (acerto),
    .pontos           (pontos)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (acerto === 1'b1) n_acerto++;
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_tick();
    tick_frame = 1'b1;
    step();
    tick_frame = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic fire();
    disparo = 1'b1;
    step();
    disparo = 1'b0;
    step();
  endtask

  task automatic test_reset();
    tick_frame = 0; ativo = 1; perdeu = 0; disparo = 0;
    x_nave = 100; y_nave = 400; x_inimigo = 600; y_inimigo = 0;
    reset = 1'b1;
    step();
    nvec++;
    if ({x_bola_aliada, y_bola_aliada, raio_bola_aliada,
         bola_ativa, acerto, pontos} !== 40'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got x=%0d y=%0d r=%0d b=%b a=%b p=%0d want all 0",
               x_bola_aliada, y_bola_aliada, raio_bola_aliada,
               bola_ativa, acerto, pontos);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_launch();
    do_reset();
    x_nave = 100; y_nave = 400; x_inimigo = 600; y_inimigo = 0;
    disparo = 1'b1;
    step();
    nvec++;
    if (x_bola_aliada !== 10'd266 || y_bola_aliada !== 10'd432 ||
        raio_bola_aliada !== 10'd3 || bola_ativa !== 1'b1) begin
      nerr++;
      $display("FAIL launch: got x=%0d y=%0d r=%0d b=%b want 266 432 3 1",
               x_bola_aliada, y_bola_aliada, raio_bola_aliada, bola_ativa);
    end
    disparo = 1'b0;
    step();
    nvec++;
    if (y_bola_aliada !== 10'd432) begin
      nerr++;
      $display("FAIL no_tick_hold: got y=%0d want 432", y_bola_aliada);
    end
    do_tick();
    nvec++;
    if (y_bola_aliada !== 10'd428) begin
      nerr++;
      $display("FAIL first_tick: got y=%0d want 428", y_bola_aliada);
    end
  endtask

  task automatic test_hold_fire();
    int launches;
    logic prev;
    do_reset();
    x_nave = 100; y_nave = 400; x_inimigo = 600; y_inimigo = 0;
    launches = 0;
    prev = 1'b0;
    disparo = 1'b1;
    step();
    if (bola_ativa && !prev) launches++;
    prev = bola_ativa;
    for (int i = 0; i < 200; i++) begin
      do_tick();
      if (bola_ativa && !prev) launches++;
      prev = bola_ativa;
    end
    nvec++;
    if (launches !== 1 || bola_ativa !== 1'b0) begin
      nerr++;
      $display("FAIL hold_fire: got launches=%0d b=%b want 1 0",
               launches, bola_ativa);
    end
    disparo = 1'b0;
    step();
    disparo = 1'b1;
    step();
    nvec++;
    if (bola_ativa !== 1'b1 || y_bola_aliada !== 10'd432) begin
      nerr++;
      $display("FAIL refire: got b=%b y=%0d want 1 432",
               bola_ativa, y_bola_aliada);
    end
    disparo = 1'b0;
  endtask

  task automatic test_hit();
    do_reset();
    x_nave = 100; y_nave = 400; x_inimigo = 110; y_inimigo = 300;
    fire();
    for (int i = 0; i < 19; i++) do_tick();
    nvec++;
    if (y_bola_aliada !== 10'd356 || bola_ativa !== 1'b1 ||
        pontos !== 8'd0) begin
      nerr++;
      $display("FAIL hit_approach: got y=%0d b=%b p=%0d want 356 1 0",
               y_bola_aliada, bola_ativa, pontos);
    end
    tick_frame = 1'b1;
    step();
    tick_frame = 1'b0;
    nvec++;
    if (acerto !== 1'b1 || pontos !== 8'd1 || raio_bola_aliada !== 10'd0 ||
        bola_ativa !== 1'b0 || y_bola_aliada !== 10'd356) begin
      nerr++;
      $display("FAIL hit_pulse: got a=%b p=%0d r=%0d b=%b y=%0d want 1 1 0 0 356",
               acerto, pontos, raio_bola_aliada, bola_ativa, y_bola_aliada);
    end
    step();
    nvec++;
    if (acerto !== 1'b0 || pontos !== 8'd1) begin
      nerr++;
      $display("FAIL hit_single: got a=%b p=%0d want 0 1", acerto, pontos);
    end
    fire();
    nvec++;
    if (bola_ativa !== 1'b0) begin
      nerr++;
      $display("FAIL fire_in_cooldown: got b=%b want 0", bola_ativa);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) do_tick();
    x_inimigo = 600; y_inimigo = 0;
    fire();
    do_tick();
    do_tick();
    perdeu = 1'b1;
    step();
    nvec++;
    if (bola_ativa !== 1'b0 || raio_bola_aliada !== 10'd0 ||
        acerto !== 1'b0 || pontos !== 8'd1) begin
      nerr++;
      $display("FAIL perdeu_abort: got b=%b r=%0d a=%b p=%0d want 0 0 0 1",
               bola_ativa, raio_bola_aliada, acerto, pontos);
    end
    perdeu = 1'b0;
    step();
    fire();
    nvec++;
    if (bola_ativa !== 1'b1) begin
      nerr++;
      $display("FAIL refire_after_abort: got b=%b want 1", bola_ativa);
    end
    do_tick();
    n_acerto = 0;
    reset = 1'b1;
    #2;
    nvec++;
    if ({x_bola_aliada, y_bola_aliada, raio_bola_aliada,
         bola_ativa, acerto, pontos} !== 40'd0) begin
      nerr++;
      $display("FAIL async_reset: got x=%0d y=%0d r=%0d b=%b a=%b p=%0d want all 0",
               x_bola_aliada, y_bola_aliada, raio_bola_aliada,
               bola_ativa, acerto, pontos);
    end
    step();
    reset = 1'b0;
    step();
    nvec++;
    if (n_acerto !== 0) begin
      nerr++;
      $display("FAIL reset_no_acerto: got pulses=%0d want 0", n_acerto);
    end
  endtask

  task automatic test_miss();
    do_reset();
    x_nave = 100; y_nave = 400; x_inimigo = 600; y_inimigo = 0;
    n_acerto = 0;
    fire();
    for (int i = 0; i < 99; i++) do_tick();
    nvec++;
    if (y_bola_aliada !== 10'd36 || bola_ativa !== 1'b1) begin
      nerr++;
      $display("FAIL miss_last_y: got y=%0d b=%b want 36 1",
               y_bola_aliada, bola_ativa);
    end
    do_tick();
    nvec++;
    if (bola_ativa !== 1'b0 || y_bola_aliada !== 10'd36 || n_acerto !== 0) begin
      nerr++;
      $display("FAIL miss_end: got b=%b y=%0d pulses=%0d want 0 36 0",
               bola_ativa, y_bola_aliada, n_acerto);
    end
    for (int i = 0; i < 7; i++) do_tick();
    fire();
    nvec++;
    if (bola_ativa !== 1'b0) begin
      nerr++;
      $display("FAIL cooldown_7: got b=%b want 0", bola_ativa);
    end
    do_tick();
    disparo = 1'b1;
    step();
    disparo = 1'b0;
    nvec++;
    if (bola_ativa !== 1'b1 || pontos !== 8'd0) begin
      nerr++;
      $display("FAIL cooldown_8: got b=%b p=%0d want 1 0", bola_ativa, pontos);
    end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    x_nave = 100; y_nave = 310; x_inimigo = 110; y_inimigo = 300;
    for (int i = 0; i < 255; i++) begin
      fire();
      do_tick();
      for (int k = 0; k < 8; k++) do_tick();
    end
    nvec++;
    if (pontos !== 8'd255) begin
      nerr++;
      $display("FAIL pontos_255: got %0d want 255", pontos);
    end
    fire();
    tick_frame = 1'b1;
    step();
    tick_frame = 1'b0;
    nvec++;
    if (acerto !== 1'b1 || pontos !== 8'd255) begin
      nerr++;
      $display("FAIL saturate: got a=%b p=%0d want 1 255", acerto, pontos);
    end
    step();
    for (int k = 0; k < 8; k++) do_tick();
  endtask

  task automatic test_hit_vs_top();
    do_reset();
    x_nave = 100; y_nave = 5; x_inimigo = 110; y_inimigo = 0;
    fire();
    nvec++;
    if (y_bola_aliada !== 10'd37 || bola_ativa !== 1'b1) begin
      nerr++;
      $display("FAIL top_launch: got y=%0d b=%b want 37 1",
               y_bola_aliada, bola_ativa);
    end
    tick_frame = 1'b1;
    step();
    tick_frame = 1'b0;
    nvec++;
    if (acerto !== 1'b1 || pontos !== 8'd1) begin
      nerr++;
      $display("FAIL hit_wins_top: got a=%b p=%0d want 1 1", acerto, pontos);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_launch();
    test_hold_fire();
    test_hit();
    test_abort();
    test_miss();
    test_saturation();
    test_hit_vs_top();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tiro_aliado.md
TIRO_ALIADO -- requirements
Module: tiro_aliado

Interface
REQ-001 SHALL have parameters: VELOCIDADE, default 4, ball pixels moved per frame; RAIO, default 3, ball radius; RECARGA_QUADROS, default 8, cooldown frames after a shot ends.
REQ-002 SHALL use one clock and reset: CLOCK_50 in 1 is the sole clock; reset in 1 is asynchronous and active-high.
REQ-003 SHALL have these ports:
- tick_frame  in  1  one-cycle pulse per video frame.
- ativo  in  1  game running.
- perdeu  in  1  game lost.
- disparo  in  1  fire button, level, synchronous to CLOCK_50.
- x_nave, y_nave  in  10 each  ship top-left, game coordinates.
- x_inimigo, y_inimigo  in  10 each  enemy top-left, game coordinates.
- x_bola_aliada, y_bola_aliada  out  10 each  ball centre, VGA counter coordinates.
- raio_bola_aliada  out  10  RAIO while ball is visible, else 0.
- bola_ativa  out  1  ball in flight.
- acerto  out  1  one-cycle hit pulse.
- pontos  out  8  hit count.

Function
REQ-004 SHALL convert game to VGA coordinates with offsets of +144 in X and +35 in Y; all sums SHALL be computed 11 bits wide, with no wrap.
REQ-005 SHALL detect a fire as a rising edge of disparo, compared against a registered copy; a held button SHALL produce only one shot.
REQ-006 SHALL implement states OCIOSO, VOANDO, ACERTO and RECARGA; the reset state SHALL be OCIOSO.
REQ-007 In OCIOSO, on a fire while ativo=1 and perdeu=0, SHALL go to VOANDO on the next edge and load:
- x_bola_aliada = x_nave+166 (144 plus ship centre 22).
- y_bola_aliada = y_nave+35-RAIO.
REQ-008 In VOANDO, bola_ativa=1 and raio_bola_aliada=RAIO; position SHALL change only on cycles where tick_frame=1.
REQ-009 On a tick_frame in VOANDO, the hit test SHALL be evaluated first against the enemy box:
- X span: x_inimigo+144 to x_inimigo+177 inclusive.
- Y span: y_inimigo+35 to y_inimigo+59 inclusive.
- Centre inside the box -> go to ACERTO; position unchanged.
REQ-010 Otherwise, if y_bola_aliada < 35+VELOCIDADE, SHALL go to RECARGA (miss); otherwise y_bola_aliada decrements by VELOCIDADE.
REQ-011 When a hit and the top-of-screen condition occur on the same tick, the hit SHALL win.
REQ-012 ACERTO SHALL last exactly one cycle:
- acerto=1.
- pontos increments, saturating at 255.
- Next state is RECARGA.
REQ-013 In RECARGA:
- bola_ativa=0 and raio_bola_aliada=0.
- An internal counter loads RECARGA_QUADROS on entry and decrements on each tick_frame.
- At 0 the state returns to OCIOSO.
- Fires are ignored.
REQ-014 In OCIOSO, bola_ativa=0 and raio_bola_aliada=0; x/y hold their last values.
REQ-015 When ativo=0 or perdeu=1 in any state, SHALL go to OCIOSO on the next edge:
- bola_ativa=0, raio=0, acerto=0.
- pontos holds.
- The cooldown counter clears.
REQ-016 tick_frame coincident with a fire in OCIOSO SHALL not move the newly loaded ball in that cycle.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 Asserting reset SHALL immediately force:
- State OCIOSO.
- x_bola_aliada=0, y_bola_aliada=0, raio_bola_aliada=0.
- bola_ativa=0, acerto=0, pontos=0.
- Cooldown counter=0, registered disparo=0.
REQ-019 Reset asserted mid-flight SHALL abort the shot with no acerto pulse.

Verification
REQ-020 Launch: x_nave=100, y_nave=400, ativo=1, disparo 0->1 -> next cycle x_bola_aliada=266, y_bola_aliada=432, raio=3, bola_ativa=1; after one tick_frame, y_bola_aliada=428.
REQ-021 Hold-fire: disparo held high for 200 frames -> exactly one shot; after the miss and 8 cooldown ticks, still no new shot until disparo falls and rises again.
REQ-022 Hit: enemy at (110,300), ball at x=266 -> ball enters Y span 335..359 -> single-cycle acerto, pontos 0->1, raio 0, RECARGA.
REQ-023 Miss: no enemy overlap, ball reaches y<39 -> RECARGA, no acerto; OCIOSO after exactly 8 tick_frames.
REQ-024 Abort: perdeu=1 mid-flight -> next cycle OCIOSO, raio=0, pontos unchanged; asynchronous reset mid-flight -> all outputs 0 without waiting for a clock edge.
REQ-025 Saturation and simultaneity: pontos preset to 255 via 255 hits, then one more hit -> pontos stays 255; a hit coincident with the top condition -> acerto asserted.
